// File: rtl/vram_responder_pkg.sv
// Shared types for the core-to-VRAM responder: address/word/core-id types,
// the responder FSM state encoding and the default core count.
package vram_responder_pkg;

   localparam int NUM_CORES_DEF = 4;
   localparam int VRAM_ADDR_W   = 16;
   localparam int VRAM_WORD_W   = 16;
   localparam int CORE_ID_W     = (NUM_CORES_DEF > 1) ? $clog2(NUM_CORES_DEF) : 1;

   typedef logic [VRAM_ADDR_W-1:0] vram_addr_t;
   typedef logic [VRAM_WORD_W-1:0] vram_word_t;
   typedef logic [CORE_ID_W-1:0]   core_id_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } vram_state_t;

   // Round-robin successor of a core id, wrapping at n.
   function automatic core_id_t next_core(input core_id_t id, input int n);
      if (int'(id) == n - 1) return '0;
      return id + core_id_t'(1);
   endfunction

endpackage

// File: rtl/vram_responder_bank.sv
// vram_bank: single-port synchronous RAM, registered read data with one
// cycle of latency. The array has no reset; only the enabled port touches it.
module vram_bank #(
   parameter int DEPTH  = 4096,
   parameter int AW     = 12,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              en,
   input  logic              w,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_q;

   // Single port: write when w=1, otherwise capture read data into the output register.
   always_ff @(posedge clk) begin
      if (en) begin
         if (w) mem_q[addr] <= d;
         else   rd_q        <= mem_q[addr];
      end
   end

   assign q = rd_q;

endmodule

// File: rtl/vram_responder.sv
// vram_responder: round-robin responder serving up to NUM_CORES cores into a
// single-port VRAM bank, one access per IDLE->ACCESS->RESP round.
// Optional feature macro: VRAM_RANGE_CHECK_EN (out-of-range addresses are
// suppressed/read as zero and flagged on err). Without it the address wraps
// to the low $clog2(VRAM_DEPTH) bits and VRAM_DEPTH must be a power of two.
module vram_responder
   import vram_responder_pkg::*;
#(
   parameter int NUM_CORES  = NUM_CORES_DEF,
   parameter int VRAM_DEPTH = 4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic       [NUM_CORES-1:0]    req_active,
   input  logic       [NUM_CORES-1:0]    req_w,
   input  vram_addr_t [NUM_CORES-1:0]    req_addr,
   input  vram_word_t [NUM_CORES-1:0]    req_data,
   output logic       [NUM_CORES-1:0]    resp_ready,
   output vram_word_t [NUM_CORES-1:0]    resp_data,
   output logic                          busy,
   output core_id_t                      grant_id,
   output logic                          err
);

   localparam int BANK_AW = (VRAM_DEPTH > 1) ? $clog2(VRAM_DEPTH) : 1;

   vram_state_t state_q, state_d;
   core_id_t    rr_q, rr_d;
   core_id_t    gid_q, gid_d;
   logic        w_q, w_d;
   vram_addr_t  addr_q, addr_d;
   vram_word_t  data_q, data_d;
   logic       [NUM_CORES-1:0] ready_q, ready_d;
   logic       [NUM_CORES-1:0] prev_ready_q;
   vram_word_t [NUM_CORES-1:0] hold_q, hold_d;

   logic [NUM_CORES-1:0] elig;
   logic                 pick_vld;
   core_id_t             pick_id;
   logic                 bank_en;
   vram_word_t           bank_q;
   vram_word_t           rd_word;
   logic                 oor_c;

   // A core served last cycle sits out one IDLE so it cannot be granted twice
   // for the same (still asserted) request.
   assign elig = req_active & ~prev_ready_q;

   // Round-robin pick: first eligible core at or after rr_q, wrapping.
   always_comb begin
      int       idx;
      core_id_t cand;
      pick_vld = 1'b0;
      pick_id  = '0;
      idx      = 0;
      cand     = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_CORES) idx = idx - NUM_CORES;
         cand = core_id_t'(idx);
         if (!pick_vld && elig[cand]) begin
            pick_vld = 1'b1;
            pick_id  = cand;
         end
      end
   end

   // FSM next state: latch the winner in IDLE, access in ACCESS, respond in RESP.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gid_d   = gid_q;
      w_d     = w_q;
      addr_d  = addr_q;
      data_d  = data_q;
      ready_d = '0;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gid_d   = pick_id;
               w_d     = req_w[pick_id];
               addr_d  = req_addr[pick_id];
               data_d  = req_data[pick_id];
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            ready_d[gid_q] = 1'b1;
            state_d        = RESP;
         end
         RESP: begin
            if (!w_q) hold_d[gid_q] = rd_word;
            rr_d    = next_core(gid_q, NUM_CORES);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         rr_q         <= '0;
         gid_q        <= '0;
         ready_q      <= '0;
         prev_ready_q <= '0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         gid_q        <= gid_d;
         ready_q      <= ready_d;
         prev_ready_q <= ready_q;
         hold_q       <= hold_d;
      end
   end

   // Latched request fields carry no reset; they are only consumed after a grant.
   always_ff @(posedge clk) begin
      w_q    <= w_d;
      addr_q <= addr_d;
      data_q <= data_d;
   end

`ifdef VRAM_RANGE_CHECK_EN
   logic oor_q;
   logic err_q;

   assign oor_c = (addr_q >= VRAM_ADDR_W'(VRAM_DEPTH));

   // Remember whether this access was out of range and keep err sticky.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         oor_q <= 1'b0;
         err_q <= 1'b0;
      end else if (state_q == ACCESS) begin
         oor_q <= oor_c;
         if (oor_c) err_q <= 1'b1;
      end
   end

   assign rd_word = oor_q ? '0 : bank_q;
   assign err     = err_q;
`else
   logic addr_hi_unused;

   assign oor_c          = 1'b0;
   assign addr_hi_unused = ^addr_q[VRAM_ADDR_W-1:BANK_AW];
   assign rd_word        = bank_q;
   assign err            = 1'b0;
`endif

   assign bank_en = (state_q == ACCESS) && !oor_c;

   vram_bank #(
      .DEPTH  (VRAM_DEPTH),
      .AW     (BANK_AW),
      .DATA_W (VRAM_WORD_W)
   ) u_bank (
      .clk  (clk),
      .en   (bank_en),
      .w    (w_q),
      .addr (addr_q[BANK_AW-1:0]),
      .d    (data_q),
      .q    (bank_q)
   );

   // Read data is visible in the RESP cycle straight from the bank register,
   // and is held per core afterwards until that core's next read.
   always_comb begin
      resp_data = hold_q;
      if (state_q == RESP && !w_q) resp_data[gid_q] = rd_word;
   end

   assign resp_ready = ready_q;
   assign busy       = (state_q != IDLE);
   assign grant_id   = gid_q;

endmodule

// File: tb/tb_vram_responder.sv
// Directed self-checking bench for vram_responder (4 cores). Inputs are driven
// and outputs sampled 1 time unit after each rising clock edge.
module tb_vram_responder;
   import vram_responder_pkg::*;

`ifdef VRAM_RANGE_CHECK_EN
   localparam int TB_DEPTH = 3000;
`else
   localparam int TB_DEPTH = 2048;
`endif

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic       [3:0]      req_active = '0;
   logic       [3:0]      req_w      = '0;
   vram_addr_t [3:0]      req_addr   = '0;
   vram_word_t [3:0]      req_data   = '0;
   logic       [3:0]      resp_ready;
   vram_word_t [3:0]      resp_data;
   logic                  busy;
   core_id_t              grant_id;
   logic                  err;

   int tests = 0;
   int fails = 0;

   vram_responder #(.NUM_CORES(4), .VRAM_DEPTH(TB_DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_active (req_active),
      .req_w      (req_w),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy),
      .grant_id   (grant_id),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic req(input int c, input logic w, input vram_addr_t a, input vram_word_t d);
      req_active[c] = 1'b1;
      req_w[c]      = w;
      req_addr[c]   = a;
      req_data[c]   = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vram_word_t rd_exp [4];
      int         waited;
      rd_exp[0] = 16'hABC; rd_exp[1] = 16'h5A5; rd_exp[2] = 16'hABC; rd_exp[3] = 16'h5A5;

      // Reset state
      tick(); tick();
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(resp_ready), 32'h0);
      chk("rst_grant", 32'(grant_id), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_data", 32'(^resp_data === 1'b0 && resp_data == '0), 32'h1);
      rst = 1'b1;
      tick();

      // Single core: write 0xABC @0x010 then read it back
      req(0, 1'b1, 16'h0010, 16'h0ABC);
      tick();
      chk("t1w_access_busy", 32'(busy), 32'h1);
      chk("t1w_access_ready", 32'(resp_ready), 32'h0);
      tick();
      chk("t1w_ready", 32'(resp_ready), 32'h1);
      req_active[0] = 1'b0;
      tick();
      chk("t1w_idle_busy", 32'(busy), 32'h0);
      chk("t1w_ready_pulse", 32'(resp_ready), 32'h0);
      tick();
      req(0, 1'b0, 16'h0010, 16'h0000);
      tick();
      chk("t1r_ready_c1", 32'(resp_ready), 32'h0);
      tick();
      chk("t1r_ready", 32'(resp_ready), 32'h1);
      chk("t1r_data", 32'(resp_data[0]), 32'h0ABC);
      req_active[0] = 1'b0;
      tick(); tick();
      chk("t1r_data_hold", 32'(resp_data[0]), 32'h0ABC);

      // Core 1 writes 0x5A5 @0x020, core 3 reads 0x020 right after (rr_ptr=1)
      req(1, 1'b1, 16'h0020, 16'h05A5);
      req(3, 1'b0, 16'h0020, 16'h0000);
      tick();
      chk("t4_grant1", 32'(grant_id), 32'h1);
      tick();
      chk("t4_ready1", 32'(resp_ready), 32'h2);
      req_active[1] = 1'b0;
      tick();
      chk("t4_gap_idle", 32'(busy), 32'h0);
      tick();
      chk("t4_grant3", 32'(grant_id), 32'h3);
      tick();
      chk("t4_ready3", 32'(resp_ready), 32'h8);
      chk("t4_data3", 32'(resp_data[3]), 32'h05A5);
      req_active[3] = 1'b0;
      tick(); tick();

      // All four cores read at once from rr_ptr=0
      req(0, 1'b0, 16'h0010, 16'h0000);
      req(1, 1'b0, 16'h0020, 16'h0000);
      req(2, 1'b0, 16'h0010, 16'h0000);
      req(3, 1'b0, 16'h0020, 16'h0000);
      for (int c = 1; c <= 12; c++) begin
         logic [31:0] exp_rdy;
         tick();
         exp_rdy = 32'h0;
         if (c % 3 == 1) chk("t2_grant", 32'(grant_id), 32'(c / 3));
         if (c % 3 == 2) begin
            exp_rdy = 32'h1 << (c / 3);
            chk("t2_data", 32'(resp_data[c / 3]), 32'(rd_exp[c / 3]));
            req_active[c / 3] = 1'b0;
         end
         chk("t2_ready", 32'(resp_ready), exp_rdy);
      end
      tick();

      // Cooldown: core 2 holds req_active, core 1 requests once
      req(2, 1'b0, 16'h0010, 16'h0000);
      tick();
      chk("t3_grant2", 32'(grant_id), 32'h2);
      tick();
      chk("t3_ready2", 32'(resp_ready), 32'h4);
      tick();
      tick();
      chk("t3_no_regrant", 32'(busy), 32'h0);
      req(1, 1'b0, 16'h0020, 16'h0000);
      waited = 0;
      while (waited < 6 && resp_ready[1] !== 1'b1) begin
         tick();
         waited++;
      end
      chk("t3_core1_served", 32'(resp_ready), 32'h2);
      chk("t3_core1_data", 32'(resp_data[1]), 32'h05A5);
      req_active[1] = 1'b0;
      tick();
      tick();
      chk("t3_regrant2", 32'(grant_id), 32'h2);
      tick();
      chk("t3_ready2b", 32'(resp_ready), 32'h4);
      req_active[2] = 1'b0;
      tick(); tick();

      // Reset asserted during ACCESS of a read
      req(3, 1'b0, 16'h0020, 16'h0000);
      tick();
      chk("t5_in_access", 32'(busy), 32'h1);
      rst = 1'b0;
      #1;
      chk("t5_rst_busy", 32'(busy), 32'h0);
      chk("t5_rst_data3", 32'(resp_data[3]), 32'h0);
      chk("t5_rst_grant", 32'(grant_id), 32'h0);
      tick();
      chk("t5_rst_ready", 32'(resp_ready), 32'h0);
      chk("t5_rst_err", 32'(err), 32'h0);
      rst = 1'b1;
      tick();
      chk("t5_fresh_grant", 32'(grant_id), 32'h3);
      tick();
      chk("t5_fresh_ready", 32'(resp_ready), 32'h8);
      chk("t5_fresh_data", 32'(resp_data[3]), 32'h05A5);
      req_active[3] = 1'b0;
      tick(); tick();

      // Out-of-range address
`ifdef VRAM_RANGE_CHECK_EN
      req(0, 1'b1, 16'd3000, 16'h0777);
      tick(); tick();
      chk("t6_oor_w_ready", 32'(resp_ready), 32'h1);
      chk("t6_oor_err", 32'(err), 32'h1);
      req_active[0] = 1'b0;
      tick(); tick();
      req(0, 1'b0, 16'd3000, 16'h0000);
      tick(); tick();
      chk("t6_oor_r_ready", 32'(resp_ready), 32'h1);
      chk("t6_oor_r_data", 32'(resp_data[0]), 32'h0);
      chk("t6_err_sticky", 32'(err), 32'h1);
`else
      req(0, 1'b1, 16'd2053, 16'h0777);
      tick(); tick();
      chk("t6_wrap_w_ready", 32'(resp_ready), 32'h1);
      req_active[0] = 1'b0;
      tick(); tick();
      req(0, 1'b0, 16'd5, 16'h0000);
      tick(); tick();
      chk("t6_wrap_r_ready", 32'(resp_ready), 32'h1);
      chk("t6_wrap_data", 32'(resp_data[0]), 32'h0777);
      chk("t6_err_tied", 32'(err), 32'h0);
`endif
      req_active[0] = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
